// File: rtl/la_pkg.sv
// Shared LA32R definitions for the decode-stage branch resolver:
// opcode constants, reset PC and the branch-kind classification.
package la_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;
  localparam logic [5:0] OP_BLT  = 6'h18;
  localparam logic [5:0] OP_BGE  = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  typedef enum logic [3:0] {
    BK_NONE,
    BK_B,
    BK_BL,
    BK_JIRL,
    BK_EQ,
    BK_NE,
    BK_LT,
    BK_GE,
    BK_LTU,
    BK_GEU
  } br_kind_e;

  function automatic br_kind_e decode_kind(input logic [5:0] op);
    case (op)
      OP_JIRL: return BK_JIRL;
      OP_B:    return BK_B;
      OP_BL:   return BK_BL;
      OP_BEQ:  return BK_EQ;
      OP_BNE:  return BK_NE;
      OP_BLT:  return BK_LT;
      OP_BGE:  return BK_GE;
      OP_BLTU: return BK_LTU;
      OP_BGEU: return BK_GEU;
      default: return BK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/la_branch_decode.sv
// Combinational LA32R control-transfer decode: classifies the instruction,
// evaluates its condition on rj/rd and forms the branch target.
module la_branch_decode
  import la_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rj_val,
  input  logic [31:0] rd_val,
  output br_kind_e    kind,
  output logic        taken_cond,
  output logic [31:0] target
);

  logic signed [31:0] offs16_sx;
  logic signed [31:0] offs26_sx;
  logic signed [31:0] rj_s;
  logic signed [31:0] rd_s;

  always_comb begin
    kind      = decode_kind(inst[31:26]);
    // Word offsets: shift by 2 first, then sign-extend from the new MSB.
    offs16_sx = {{14{inst[25]}}, inst[25:10], 2'b00};
    offs26_sx = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    rj_s      = rj_val;
    rd_s      = rd_val;

    taken_cond = 1'b0;
    target     = pc + $unsigned(offs16_sx);
    case (kind)
      BK_B, BK_BL: begin
        taken_cond = 1'b1;
        target     = pc + $unsigned(offs26_sx);
      end
      BK_JIRL: begin
        taken_cond = 1'b1;
        target     = rj_val + $unsigned(offs16_sx);
      end
      BK_EQ:   taken_cond = (rj_val == rd_val);
      BK_NE:   taken_cond = (rj_val != rd_val);
      BK_LT:   taken_cond = (rj_s < rd_s);
      BK_GE:   taken_cond = (rj_s >= rd_s);
      BK_LTU:  taken_cond = (rj_val < rd_val);
      BK_GEU:  taken_cond = (rj_val >= rd_val);
      default: taken_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_unit.sv
// Decode-stage branch resolver: holds the decode register, resolves branches
// with zero-cycle latency, squashes the wrong-path slot and counts events.
module id_branch_unit #(
  parameter logic [31:0] RESET_PC = la_pkg::RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fs_valid,
  input  logic [31:0]      fs_pc,
  input  logic [31:0]      fs_inst,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic             br_taken,
  output logic [31:0]      br_target,
  output logic             ds_valid,
  output logic [31:0]      ds_pc,
  output logic [31:0]      ds_inst,
  output logic             link_we,
  output logic [4:0]       link_addr,
  output logic [31:0]      link_data,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] squash_cnt
);
  import la_pkg::*;

  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  br_kind_e    kind;
  logic        taken_cond;
  logic [31:0] dec_target;

  la_branch_decode u_decode (
    .inst       (id_inst_q),
    .pc         (id_pc_q),
    .rj_val     (rf_rdata1),
    .rd_val     (rf_rdata2),
    .kind       (kind),
    .taken_cond (taken_cond),
    .target     (dec_target)
  );

  // Stage boundary: decode register output, resolved combinationally.
  always_comb begin
    rf_raddr1 = id_inst_q[9:5];
    rf_raddr2 = id_inst_q[4:0];
    br_taken  = id_valid_q & taken_cond;
    br_target = br_taken ? dec_target : id_pc_q + 32'd4;
    ds_valid  = id_valid_q;
    ds_pc     = id_valid_q ? id_pc_q : RESET_PC;
    ds_inst   = id_inst_q;
    link_we   = id_valid_q & ((kind == BK_BL) | (kind == BK_JIRL));
    link_addr = (kind == BK_BL) ? 5'd1 : id_inst_q[4:0];
    link_data = ds_pc + 32'd4;
    taken_cnt  = taken_cnt_q;
    squash_cnt = squash_cnt_q;
  end

  // The instruction fetched behind a taken branch enters decode already dead.
  always_comb begin
    id_valid_d   = fs_valid & ~br_taken;
    id_pc_d      = fs_pc;
    id_inst_d    = fs_inst;
    taken_cnt_d  = taken_cnt_q + CNT_W'(br_taken);
    squash_cnt_d = squash_cnt_q + CNT_W'(fs_valid & br_taken);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= RESET_PC;
      id_inst_q    <= 32'd0;
      taken_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      taken_cnt_q  <= taken_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_branch_unit.sv
// Bench for id_branch_unit: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_id_branch_unit;

  localparam logic [31:0] RPC = 32'h1c000000;
  localparam logic [31:0] NOP = 32'h03400000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_valid;
  logic [31:0] fs_pc, fs_inst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_valid;
  logic [31:0] ds_pc, ds_inst;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic [31:0] taken_cnt, squash_cnt;

  logic [31:0] regs [32];

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  logic        started = 1'b0;
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_tc, m_sc;

  id_branch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .fs_valid   (fs_valid),
    .fs_pc      (fs_pc),
    .fs_inst    (fs_inst),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ds_valid   (ds_valid),
    .ds_pc      (ds_pc),
    .ds_inst    (ds_inst),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .link_data  (link_data),
    .taken_cnt  (taken_cnt),
    .squash_cnt (squash_cnt)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] enc16(input logic [5:0] op, input logic [15:0] o,
                                        input logic [4:0] rj, input logic [4:0] rd);
    return {op, o, rj, rd};
  endfunction

  function automatic logic [31:0] enc26(input logic [5:0] op, input logic [25:0] o);
    return {op, o[15:0], o[25:16]};
  endfunction

  // Architectural meaning of one instruction: is it taken, where, does it link.
  function automatic void model_eval(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] rj, input logic [31:0] rd,
                                     output logic tk, output logic [31:0] tgt,
                                     output logic lnk);
    int o16, o26;
    o16 = int'($signed(inst[25:10])) * 4;
    o26 = int'($signed({inst[9:0], inst[25:10]})) * 4;
    tk  = 1'b0;
    lnk = 1'b0;
    tgt = pc + o16;
    case (inst[31:26])
      6'h13: begin tk = 1'b1; lnk = 1'b1; tgt = rj + o16; end
      6'h14: begin tk = 1'b1; tgt = pc + o26; end
      6'h15: begin tk = 1'b1; lnk = 1'b1; tgt = pc + o26; end
      6'h16: tk = (rj == rd);
      6'h17: tk = (rj != rd);
      6'h18: tk = ($signed(rj) < $signed(rd));
      6'h19: tk = ($signed(rj) >= $signed(rd));
      6'h1a: tk = (rj < rd);
      6'h1b: tk = (rj >= rd);
      default: tk = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model_update
    logic        tk, lnk, etk;
    logic [31:0] tgt;
    model_eval(m_inst, m_pc, regs[m_inst[9:5]], regs[m_inst[4:0]], tk, tgt, lnk);
    etk = started & m_valid & tk;
    started <= 1'b1;
    if (reset) begin
      m_valid <= 1'b0;
      m_pc    <= RPC;
      m_inst  <= 32'd0;
      m_tc    <= 32'd0;
      m_sc    <= 32'd0;
    end else begin
      m_valid <= fs_valid & ~etk;
      m_pc    <= fs_pc;
      m_inst  <= fs_inst;
      m_tc    <= m_tc + 32'(etk);
      m_sc    <= m_sc + 32'(fs_valid & etk);
    end
  end

  always @(negedge clk) begin : compare
    logic        tk, lnk, etk;
    logic [31:0] tgt, epc;
    if (started) begin
      model_eval(m_inst, m_pc, regs[m_inst[9:5]], regs[m_inst[4:0]], tk, tgt, lnk);
      etk = m_valid & tk;
      epc = m_valid ? m_pc : RPC;
      chk("ds_valid", 32'(ds_valid), 32'(m_valid));
      chk("ds_pc", ds_pc, epc);
      chk("ds_inst", ds_inst, m_inst);
      chk("rf_raddr1", 32'(rf_raddr1), 32'(m_inst[9:5]));
      chk("rf_raddr2", 32'(rf_raddr2), 32'(m_inst[4:0]));
      chk("br_taken", 32'(br_taken), 32'(etk));
      chk("br_target", br_target, etk ? tgt : m_pc + 32'd4);
      chk("link_we", 32'(link_we), 32'(m_valid & lnk));
      if (m_valid & lnk)
        chk("link_addr", 32'(link_addr), (m_inst[31:26] == 6'h15) ? 32'd1 : 32'(m_inst[4:0]));
      chk("link_data", link_data, epc + 32'd4);
      chk("taken_cnt", taken_cnt, m_tc);
      chk("squash_cnt", squash_cnt, m_sc);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] i);
    fs_valid = v;
    fs_pc    = p;
    fs_inst  = i;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [5:0] op;
    int         r;
    reset    = 1'b1;
    fs_valid = 1'b0;
    fs_pc    = 32'd0;
    fs_inst  = 32'd0;
    for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ds_valid", 32'(ds_valid), 32'd0);
    chk("rst_ds_pc", ds_pc, RPC);
    chk("rst_br_taken", 32'(br_taken), 32'd0);
    chk("rst_link_we", 32'(link_we), 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    chk("rst_squash_cnt", squash_cnt, 32'd0);

    reset = 1'b0;
    cyc(1'b1, RPC, NOP);
    chk("nop_ds_valid", 32'(ds_valid), 32'd1);
    chk("nop_ds_pc", ds_pc, 32'h1c000000);
    chk("nop_br_taken", 32'(br_taken), 32'd0);
    chk("nop_taken_cnt", taken_cnt, 32'd0);

    regs[4] = 32'd7;
    regs[5] = 32'd7;
    cyc(1'b1, 32'h1c000010, enc16(6'h16, 16'd4, 5'd4, 5'd5));
    chk("beq_taken", 32'(br_taken), 32'd1);
    chk("beq_target", br_target, 32'h1c000020);
    cyc(1'b1, 32'h1c000014, NOP);
    chk("beq_squash_valid", 32'(ds_valid), 32'd0);
    chk("beq_squash_cnt", squash_cnt, 32'd1);
    chk("beq_taken_cnt", taken_cnt, 32'd1);
    cyc(1'b1, 32'h1c000020, NOP);

    regs[4] = 32'hffffffff;
    regs[5] = 32'd1;
    cyc(1'b1, 32'h1c000024, enc16(6'h18, 16'd2, 5'd4, 5'd5));
    chk("blt_taken", 32'(br_taken), 32'd1);
    chk("blt_target", br_target, 32'h1c00002c);
    cyc(1'b1, 32'h1c000028, NOP);
    chk("blt_squash_valid", 32'(ds_valid), 32'd0);
    cyc(1'b1, 32'h1c00002c, enc16(6'h1a, 16'd2, 5'd4, 5'd5));
    chk("bltu_taken", 32'(br_taken), 32'd0);
    chk("bltu_target", br_target, 32'h1c000030);
    cyc(1'b1, 32'h1c000030, NOP);
    chk("bltu_next_valid", 32'(ds_valid), 32'd1);

    cyc(1'b1, 32'h1c000100, enc26(6'h15, 26'h3ffffff));
    chk("bl_target", br_target, 32'h1c0000fc);
    chk("bl_link_we", 32'(link_we), 32'd1);
    chk("bl_link_addr", 32'(link_addr), 32'd1);
    chk("bl_link_data", link_data, 32'h1c000104);
    cyc(1'b1, 32'h1c000104, NOP);

    regs[3] = 32'hfffffff0;
    cyc(1'b1, 32'h1c000200, enc16(6'h13, 16'h0010, 5'd3, 5'd2));
    chk("jirl_target", br_target, 32'h00000030);
    chk("jirl_link_addr", 32'(link_addr), 32'd2);
    chk("jirl_link_we", 32'(link_we), 32'd1);
    cyc(1'b1, 32'h1c000204, NOP);
    cyc(1'b1, 32'h00000030, NOP);

    cyc(1'b1, 32'h1c000300, enc26(6'h14, 26'h40));
    chk("b_target", br_target, 32'h1c000400);
    cyc(1'b1, 32'h1c000304, enc16(6'h17, 16'd4, 5'd4, 5'd5));
    chk("bne_squashed_valid", 32'(ds_valid), 32'd0);
    chk("bne_squashed_taken", 32'(br_taken), 32'd0);
    cyc(1'b1, 32'h1c000400, NOP);
    chk("bb_taken_cnt", taken_cnt, 32'd5);
    chk("bb_squash_cnt", squash_cnt, 32'd5);

    cyc(1'b1, 32'h1c000500, enc26(6'h14, 26'h10));
    chk("pre_reset_taken", 32'(br_taken), 32'd1);
    reset = 1'b1;
    cyc(1'b1, 32'h1c000504, NOP);
    chk("mid_rst_ds_valid", 32'(ds_valid), 32'd0);
    chk("mid_rst_ds_pc", ds_pc, RPC);
    chk("mid_rst_ds_inst", ds_inst, 32'd0);
    chk("mid_rst_br_taken", 32'(br_taken), 32'd0);
    chk("mid_rst_link_we", 32'(link_we), 32'd0);
    chk("mid_rst_taken_cnt", taken_cnt, 32'd0);
    chk("mid_rst_squash_cnt", squash_cnt, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 32; k++) regs[k] = 32'($urandom_range(0, 3));
    repeat (3000) begin
      r = $urandom_range(0, 31);
      regs[r] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      r  = $urandom_range(0, 11);
      op = (r < 9) ? 6'(6'h13 + r) : 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 4) != 0, $urandom, {op, 26'($urandom)});
    end
    reset = 1'b0;
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
